dcim_cmd_rx: RTL and testbench

- Pin-level command receiver that sits directly upstream of the TinyDCIM compute array inside the tt_um top.
- Takes a host byte stream from the dedicated input pins using a toggle-strobe/toggle-ack handshake.
- Decodes opcodes and drives the array's weight-row write port, activation write port and start pulse.
- Reports a sticky error flag for illegal commands and for starts issued while the array is busy.

---
 rtl/dcim_pkg.sv | 19 +
 rtl/dcim_cmd_rx_if.sv | 9 +
 rtl/dcim_sync_edge.sv | 24 ++
 rtl/dcim_cmd_rx.sv | 136 +++++++++++++
 tb/tb_dcim_cmd_rx.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/dcim_pkg.sv
// Shared opcodes, FSM state encoding and default geometry for the TinyDCIM command receiver.
package dcim_pkg;

    localparam int DCIM_ROWS = 8;
    localparam int DCIM_COLS = 8;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [3:0] OP_WROW   = 4'h1;   // upper nibble; lower nibble carries the row
    localparam logic [7:0] OP_LDACT  = 8'h20;
    localparam logic [7:0] OP_START  = 8'h30;
    localparam logic [7:0] OP_CLRERR = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        W_DATA = 2'd1,
        A_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/dcim_cmd_rx_if.sv
// Host byte-stream link: data byte plus toggle strobe from the host, toggle ack back to it.
interface dcim_cmd_rx_if;
    logic [7:0] host_data;
    logic       host_stb;
    logic       host_ack;

    modport master (output host_data, output host_stb, input host_ack);
    modport slave  (input host_data, input host_stb, output host_ack);
endinterface

// File: rtl/dcim_sync_edge.sv
// Two-flop synchronizer for an asynchronous toggle line; pulses evt for one cycle per toggle.
module dcim_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic evt
);
    logic sync_d, sync_q, prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_d <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_d <= async_in;
            sync_q <= sync_d;
            prev_q <= sync_q;
        end
    end

    assign evt = sync_q ^ prev_q;

endmodule

// File: rtl/dcim_cmd_rx.sv
// Pin-level command decoder feeding the TinyDCIM array write ports and start pulse.
// Optional payload idle timeout is built when DCIM_CMD_TIMEOUT_EN is defined.
module dcim_cmd_rx
    import dcim_pkg::*;
#(
    parameter int ROWS        = DCIM_ROWS,
    parameter int COLS        = DCIM_COLS,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                                clk,
    input  logic                                rst_n,
    dcim_cmd_rx_if.slave                        host,
    input  logic                                arr_busy,
    output logic                                w_we,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] w_addr,
    output logic [COLS-1:0]                     w_data,
    output logic                                a_we,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] a_idx,
    output logic [7:0]                          a_data,
    output logic                                start,
    output logic                                err,
    output logic [1:0]                          state_dbg
);
    localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

    // Geometry outside what the opcode format can address leaves this block empty on purpose.
    if (ROWS > 16 || COLS != 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
    end

    logic          stb_evt;
    logic [7:0]    rx_byte;
    state_t        state;
    logic [AW-1:0] row;
    logic [AW-1:0] idx;
    logic          ack_q;
    logic          tmo_hit;

    dcim_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (host.host_stb),
        .evt      (stb_evt)
    );

    assign rx_byte       = host.host_data;
    assign host.host_ack = ack_q;
    assign state_dbg     = state;

`ifdef DCIM_CMD_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] tmo_cnt;

    // Counts idle cycles inside a payload state; any byte event restarts the window.
    always_ff @(posedge clk) begin
        if (!rst_n || stb_evt || state == IDLE) begin
            tmo_cnt <= 16'd0;
        end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            row    <= '0;
            idx    <= '0;
            ack_q  <= 1'b0;
            err    <= 1'b0;
            w_we   <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
            a_we   <= 1'b0;
            a_idx  <= '0;
            a_data <= '0;
            start  <= 1'b0;
        end else begin
            w_we  <= 1'b0;
            a_we  <= 1'b0;
            start <= 1'b0;
            if (stb_evt) begin
                ack_q <= ~ack_q;
                case (state)
                    IDLE: begin
                        if (rx_byte[7:4] == OP_WROW) begin
                            if (int'(rx_byte[3:0]) < ROWS) begin
                                row   <= rx_byte[AW-1:0];
                                state <= W_DATA;
                            end else begin
                                err <= 1'b1;
                            end
                        end else begin
                            case (rx_byte)
                                OP_NOP: ;
                                OP_LDACT: begin
                                    idx   <= '0;
                                    state <= A_DATA;
                                end
                                OP_START: begin
                                    if (arr_busy) err   <= 1'b1;
                                    else          start <= 1'b1;
                                end
                                OP_CLRERR: err <= 1'b0;
                                default:   err <= 1'b1;
                            endcase
                        end
                    end
                    W_DATA: begin
                        w_we   <= 1'b1;
                        w_addr <= row;
                        w_data <= rx_byte[COLS-1:0];
                        state  <= IDLE;
                    end
                    A_DATA: begin
                        a_we   <= 1'b1;
                        a_idx  <= idx;
                        a_data <= rx_byte;
                        idx    <= idx + 1'b1;
                        if (idx == AW'(ROWS - 1)) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (tmo_hit) begin
                state <= IDLE;
                err   <= 1'b1;
            end else if (!(state inside {IDLE, W_DATA, A_DATA})) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_dcim_cmd_rx.sv
// Directed bench for dcim_cmd_rx: reset, weight/activation loads, start gating, errors, timeout.
module tb_dcim_cmd_rx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       arr_busy;
    logic       w_we, a_we, start, err;
    logic [2:0] w_addr, a_idx;
    logic [7:0] w_data, a_data;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    int         ack_cnt = 0;
    int         w_cnt = 0;
    int         a_cnt = 0;
    int         start_cnt = 0;
    logic       prev_ack = 1'b0;
    logic [2:0] w_addr_l;
    logic [7:0] w_data_l;
    logic [2:0] a_idx_log [0:31];
    logic [7:0] a_dat_log [0:31];

    dcim_cmd_rx_if host ();

    dcim_cmd_rx #(.ROWS(8), .COLS(8), .TIMEOUT_CYC(100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (host.slave),
        .arr_busy  (arr_busy),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .a_we      (a_we),
        .a_idx     (a_idx),
        .a_data    (a_data),
        .start     (start),
        .err       (err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (host.host_ack !== prev_ack) ack_cnt <= ack_cnt + 1;
            if (w_we === 1'b1) begin
                w_cnt    <= w_cnt + 1;
                w_addr_l <= w_addr;
                w_data_l <= w_data;
            end
            if (a_we === 1'b1) begin
                a_idx_log[a_cnt[4:0]] <= a_idx;
                a_dat_log[a_cnt[4:0]] <= a_data;
                a_cnt <= a_cnt + 1;
            end
            if (start === 1'b1) start_cnt <= start_cnt + 1;
        end
        prev_ack <= host.host_ack;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int want;
        int n;
        want = ack_cnt + 1;
        n = 0;
        @(negedge clk);
        host.host_data = b;
        host.host_stb  = ~host.host_stb;
        while (ack_cnt != want && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (ack_cnt != want) chk("ack_timeout", 32'(ack_cnt), 32'(want));
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        arr_busy       = 1'b0;
        host.host_data = 8'h00;
        host.host_stb  = 1'b0;

        // Reset held for 3 clocks while the strobe toggles (ends low)
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            host.host_stb = ~host.host_stb;
            #1;
            chk("reset_outs", {25'd0, host.host_ack, w_we, a_we, start, err, state_dbg},
                32'd0);
        end
        @(negedge clk);
        host.host_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("reset_no_ack", 32'(ack_cnt), 32'd0);
        chk("reset_state", {30'd0, state_dbg}, 32'd0);

        // Weight row write
        send_byte(8'h13);
        chk("wrow_state", {30'd0, state_dbg}, 32'd1);
        chk("wrow_no_we", 32'(w_cnt), 32'd0);
        send_byte(8'hA5);
        chk("wdata_cnt", 32'(w_cnt), 32'd1);
        chk("wdata_addr", {29'd0, w_addr_l}, 32'd3);
        chk("wdata_data", {24'd0, w_data_l}, 32'hA5);
        chk("wdata_acks", 32'(ack_cnt), 32'd2);
        chk("wdata_state", {30'd0, state_dbg}, 32'd0);
        chk("wdata_hold", {21'd0, w_addr, w_data}, {21'd0, 3'd3, 8'hA5});

        // Activation load of 8 bytes
        send_byte(8'h20);
        chk("ldact_state", {30'd0, state_dbg}, 32'd2);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        chk("act_cnt", 32'(a_cnt), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("act_idx", {29'd0, a_idx_log[i]}, 32'(i));
            chk("act_data", {24'd0, a_dat_log[i]}, 32'(i + 1));
        end
        chk("act_state", {30'd0, state_dbg}, 32'd0);
        send_byte(8'h13);
        chk("post_act_opcode", {30'd0, state_dbg}, 32'd1);
        send_byte(8'h00);
        chk("w2_cnt", 32'(w_cnt), 32'd2);
        chk("w2_data", {21'd0, w_addr_l, w_data_l}, {21'd0, 3'd3, 8'h00});
        chk("w2_state", {30'd0, state_dbg}, 32'd0);

        // Start gating on arr_busy
        send_byte(8'h30);
        chk("start_pulse", 32'(start_cnt), 32'd1);
        chk("start_err", {31'd0, err}, 32'd0);
        arr_busy = 1'b1;
        send_byte(8'h30);
        chk("busy_no_start", 32'(start_cnt), 32'd1);
        chk("busy_err", {31'd0, err}, 32'd1);
        arr_busy = 1'b0;
        send_byte(8'hF0);
        chk("clrerr", {31'd0, err}, 32'd0);

        // Illegal opcodes and out-of-range rows
        send_byte(8'h77);
        chk("ill77_err", {31'd0, err}, 32'd1);
        chk("ill77_state", {30'd0, state_dbg}, 32'd0);
        send_byte(8'hF0);
        send_byte(8'h1F);
        chk("ill1F_err", {31'd0, err}, 32'd1);
        chk("ill1F_state", {30'd0, state_dbg}, 32'd0);
        send_byte(8'hF0);
        send_byte(8'h18);
        chk("ill18_err", {31'd0, err}, 32'd1);
        chk("ill_no_writes", {16'(w_cnt), 16'(a_cnt)}, {16'd2, 16'd8});
        send_byte(8'hF0);
        send_byte(8'h00);
        chk("nop_err", {31'd0, err}, 32'd0);
        chk("nop_state", {30'd0, state_dbg}, 32'd0);

        // Partial activation load followed by a long host silence
        send_byte(8'h20);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        chk("part_cnt", 32'(a_cnt), 32'd11);
        chk("part_idx", {29'd0, a_idx_log[10]}, 32'd2);
        repeat (110) @(negedge clk);
`ifdef DCIM_CMD_TIMEOUT_EN
        chk("tmo_state", {30'd0, state_dbg}, 32'd0);
        chk("tmo_err", {31'd0, err}, 32'd1);
`else
        chk("notmo_state", {30'd0, state_dbg}, 32'd2);
        chk("notmo_err", {31'd0, err}, 32'd0);
`endif
        chk("tmo_no_write", 32'(a_cnt), 32'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
